// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-way round-robin arbiter with registered one-hot grant.
// Ports: clk, rst (sync, active-high), req[7:0], done -> gnt[7:0],
//   gnt_idx[2:0], gnt_valid, timeout.
// Optional hold limit enabled by defining ARB_TIMEOUT_EN (uses MAX_HOLD).
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
    $error("rr_arbiter8: MAX_HOLD out of range 2..255");
  end

  state_t     r_state;
  logic [2:0] r_ptr;
  logic [7:0] r_gnt;
  logic [2:0] r_gnt_idx;
  logic       r_gnt_valid;
  logic       r_timeout;

  state_t     w_state_nxt;
  logic [2:0] w_ptr_nxt;
  logic [7:0] w_gnt_nxt;
  logic [2:0] w_idx_nxt;
  logic       w_vld_nxt;
  logic       w_to_nxt;

  logic [2:0] w_cand;
  logic [2:0] w_pick;
  logic       w_found;
  logic       w_to;
  logic       w_rel;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] r_hold;

  // Zero during the grant cycle, so the owner keeps the
  // resource for that cycle plus MAX_HOLD more.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold <= 8'd0;
    end else if (r_state == IDLE) begin
      r_hold <= 8'd0;
    end else begin
      r_hold <= r_hold + 8'd1;
    end
  end

  assign w_to = (r_state == GRANT) &&
                (r_hold == 8'(MAX_HOLD));
`else
  assign w_to = 1'b0;
`endif

  // Scan ptr, ptr+1, ... wrapping mod 8; first set bit wins.
  always_comb begin
    w_cand  = 3'd0;
    w_pick  = 3'd0;
    w_found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      w_cand = r_ptr + 3'(i);
      if (!w_found && req[w_cand]) begin
        w_pick  = w_cand;
        w_found = 1'b1;
      end
    end
  end

  assign w_rel = (r_state == GRANT) &&
                 (done || !req[r_gnt_idx] || w_to);

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_gnt_nxt   = r_gnt;
    w_idx_nxt   = r_gnt_idx;
    w_vld_nxt   = r_gnt_valid;
    w_to_nxt    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = GRANT;
          w_gnt_nxt   = 8'd1 << w_pick;
          w_idx_nxt   = w_pick;
          w_vld_nxt   = 1'b1;
        end
      end
      GRANT: begin
        if (w_rel) begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = 8'd0;
          w_idx_nxt   = 3'd0;
          w_vld_nxt   = 1'b0;
          w_ptr_nxt   = r_gnt_idx + 3'd1;
          w_to_nxt    = w_to;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= 3'd0;
      r_gnt       <= 8'd0;
      r_gnt_idx   <= 3'd0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_idx   <= w_idx_nxt;
      r_gnt_valid <= w_vld_nxt;
      r_timeout   <= w_to_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_idx   = r_gnt_idx;
  assign gnt_valid = r_gnt_valid;
  assign timeout   = r_timeout;

endmodule
